// File: rtl/mem_arbiter.sv
// Two-port arbiter (instruction fetch / data) in front of a shared single-port memory.
// Data has priority; a starvation counter forces a fetch grant after STARVE_LIMIT data grants.
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int AW           = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [31:0]   if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [31:0]   d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [31:0]   d_rdata,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic          mem_ack,
  input  logic [31:0]   mem_rdata
);

  localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, IF_BUSY, D_BUSY} state_t;

  state_t        state, state_n;
  logic [SW-1:0] starve_cnt, starve_n;
  logic          mem_req_n, mem_we_n;
  logic [AW-1:0] mem_addr_n;
  logic [31:0]   mem_wdata_n, if_rdata_n, d_rdata_n;
  logic          if_gnt_n, d_gnt_n, if_rvalid_n, d_rvalid_n;
  logic          fetch_wins;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      starve_cnt <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      if_gnt     <= 1'b0;
      d_gnt      <= 1'b0;
      if_rvalid  <= 1'b0;
      d_rvalid   <= 1'b0;
      if_rdata   <= '0;
      d_rdata    <= '0;
    end else begin
      state      <= state_n;
      starve_cnt <= starve_n;
      mem_req    <= mem_req_n;
      mem_we     <= mem_we_n;
      mem_addr   <= mem_addr_n;
      mem_wdata  <= mem_wdata_n;
      if_gnt     <= if_gnt_n;
      d_gnt      <= d_gnt_n;
      if_rvalid  <= if_rvalid_n;
      d_rvalid   <= d_rvalid_n;
      if_rdata   <= if_rdata_n;
      d_rdata    <= d_rdata_n;
    end
  end

  // All outputs are registered: this block computes their values for the next edge.
  always_comb begin
    state_n     = state;
    starve_n    = starve_cnt;
    mem_req_n   = mem_req;
    mem_we_n    = mem_we;
    mem_addr_n  = mem_addr;
    mem_wdata_n = mem_wdata;
    if_rdata_n  = if_rdata;
    d_rdata_n   = d_rdata;
    if_gnt_n    = 1'b0;
    d_gnt_n     = 1'b0;
    if_rvalid_n = 1'b0;
    d_rvalid_n  = 1'b0;
    fetch_wins  = if_req && (!d_req || starve_cnt == LIMIT);

    unique case (state)
      IDLE: begin
        if (fetch_wins) begin
          state_n    = IF_BUSY;
          mem_req_n  = 1'b1;
          mem_we_n   = 1'b0;
          mem_addr_n = if_addr;
          if_gnt_n   = 1'b1;
          starve_n   = '0;
        end else if (d_req) begin
          state_n     = D_BUSY;
          mem_req_n   = 1'b1;
          mem_we_n    = d_we;
          mem_addr_n  = d_addr;
          mem_wdata_n = d_wdata;
          d_gnt_n     = 1'b1;
          if (if_req && starve_cnt != LIMIT) starve_n = starve_cnt + SW'(1);
        end
      end
      IF_BUSY: begin
        if (mem_ack) begin
          state_n     = IDLE;
          mem_req_n   = 1'b0;
          if_rvalid_n = 1'b1;
          if_rdata_n  = mem_rdata;
        end
      end
      D_BUSY: begin
        if (mem_ack) begin
          state_n    = IDLE;
          mem_req_n  = 1'b0;
          d_rvalid_n = 1'b1;
          d_rdata_n  = mem_rdata;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule
